// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming K_p x K_p sliding-window generator (stride 1, no padding) for raster pixels.
// Define CONV_WIN_PERF_EN to add the stall_cnt_o / win_cnt_o performance counters.
module conv_window_gen #(
  parameter int N_p    = 4,
  parameter int K_p    = 2,
  parameter int R_p    = 16,
  parameter int C_p    = 16,
  parameter int DATA_W = 32,
  localparam int CH_W  = (N_p > 1) ? $clog2(N_p) : 1,
  localparam int ROW_W = (R_p > 1) ? $clog2(R_p) : 1,
  localparam int COL_W = (C_p > 1) ? $clog2(C_p) : 1,
  localparam int WIN_W = K_p * K_p * DATA_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              pix_v_i,
  input  logic [DATA_W-1:0] pix_i,
  output logic              pix_ready_o,
  output logic              win_v_o,
  output logic [WIN_W-1:0]  win_o,
  output logic [CH_W-1:0]   win_ch_o,
  output logic [ROW_W-1:0]  win_row_o,
  output logic [COL_W-1:0]  win_col_o,
  output logic              win_last_o,
  input  logic              win_ready_i
`ifdef CONV_WIN_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       win_cnt_o
`endif
);

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              win_v_q, win_v_d;
  logic              win_last_q, win_last_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [CH_W-1:0]   win_ch_q, win_ch_d;
  logic [ROW_W-1:0]  win_row_q, win_row_d;
  logic [COL_W-1:0]  win_col_q, win_col_d;

  logic [DATA_W-1:0] line_mem [K_p-1][C_p];
  logic [DATA_W-1:0] new_col [K_p];

  logic pix_acc, win_take, emit;
  logic col_end, row_end, ch_end;

  assign pix_ready_o = !win_v_q || win_ready_i;
  assign win_v_o     = win_v_q;
  assign win_o       = win_q;
  assign win_ch_o    = win_ch_q;
  assign win_row_o   = win_row_q;
  assign win_col_o   = win_col_q;
  assign win_last_o  = win_last_q;

  // Raster position of the pixel currently offered on pix_i.
  always_comb begin
    pix_acc  = pix_v_i && pix_ready_o;
    win_take = win_v_q && win_ready_i;
    col_end  = (col_q == COL_W'(C_p - 1));
    row_end  = (row_q == ROW_W'(R_p - 1));
    ch_end   = (ch_q == CH_W'(N_p - 1));
    emit     = pix_acc && (row_q >= ROW_W'(K_p - 1)) && (col_q >= COL_W'(K_p - 1));
    col_d    = col_q;
    row_d    = row_q;
    ch_d     = ch_q;
    if (pix_acc) begin
      col_d = col_end ? '0 : col_q + COL_W'(1);
      if (col_end) begin
        row_d = row_end ? '0 : row_q + ROW_W'(1);
        if (row_end) begin
          ch_d = ch_end ? '0 : ch_q + CH_W'(1);
        end
      end
    end
  end

  // Window shift: line buffers supply the rows above the incoming pixel, oldest row on top.
  always_comb begin
    for (int kr = 0; kr < K_p - 1; kr++) begin
      new_col[kr] = line_mem[kr][col_q];
    end
    new_col[K_p-1] = pix_i;

    win_d = win_q;
    if (pix_acc) begin
      for (int kr = 0; kr < K_p; kr++) begin
        for (int kc = 0; kc < K_p; kc++) begin
          if (kc < K_p - 1) begin
            win_d[(kr*K_p+kc)*DATA_W +: DATA_W] = win_q[(kr*K_p+kc+1)*DATA_W +: DATA_W];
          end else begin
            win_d[(kr*K_p+kc)*DATA_W +: DATA_W] = new_col[kr];
          end
        end
      end
    end

    win_v_d    = win_v_q;
    win_last_d = win_last_q;
    win_ch_d   = win_ch_q;
    win_row_d  = win_row_q;
    win_col_d  = win_col_q;
    if (emit) begin
      win_v_d    = 1'b1;
      win_last_d = ch_end && row_end && col_end;
      win_ch_d   = ch_q;
      win_row_d  = row_q - ROW_W'(K_p - 1);
      win_col_d  = col_q - COL_W'(K_p - 1);
    end else if (win_take) begin
      win_v_d    = 1'b0;
      win_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      col_q      <= '0;
      row_q      <= '0;
      ch_q       <= '0;
      win_v_q    <= 1'b0;
      win_last_q <= 1'b0;
      win_q      <= '0;
      win_ch_q   <= '0;
      win_row_q  <= '0;
      win_col_q  <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      ch_q       <= ch_d;
      win_v_q    <= win_v_d;
      win_last_q <= win_last_d;
      win_q      <= win_d;
      win_ch_q   <= win_ch_d;
      win_row_q  <= win_row_d;
      win_col_q  <= win_col_d;
    end
  end

  // Line buffers act as a vertical shift per column; contents are never observed before rewrite.
  always_ff @(posedge clk_i) begin
    if (pix_acc) begin
      for (int i = 0; i < K_p - 2; i++) begin
        line_mem[i][col_q] <= line_mem[i+1][col_q];
      end
      line_mem[K_p-2][col_q] <= pix_i;
    end
  end

`ifdef CONV_WIN_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] win_cnt_q, win_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    win_cnt_d   = win_cnt_q;
    if (win_v_q && !win_ready_i) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (win_take) begin
      win_cnt_d = win_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cnt_q <= '0;
      win_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      win_cnt_q   <= win_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign win_cnt_o   = win_cnt_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: two instances (K=2 4x4 2ch, K=3 6x6 4ch) checked against a frame-level window model.
module tb_conv_window_gen;
  localparam int DW = 32;
  localparam int NA = 2, KA = 2, RA = 4, CA = 4;
  localparam int NB = 4, KB = 3, RB = 6, CB = 6;
  localparam int MW = 9 * DW;

  typedef struct {
    logic [MW-1:0] d;
    logic [31:0]   ch;
    logic [31:0]   row;
    logic [31:0]   col;
    logic          last;
  } win_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic pv_a, pr_a, wv_a, wl_a, wr_a;
  logic [DW-1:0] px_a;
  logic [KA*KA*DW-1:0] w_a;
  logic [0:0] ch_a;
  logic [1:0] row_a, col_a;
  logic pv_b, pr_b, wv_b, wl_b, wr_b;
  logic [DW-1:0] px_b;
  logic [KB*KB*DW-1:0] w_b;
  logic [1:0] ch_b;
  logic [2:0] row_b, col_b;
`ifdef CONV_WIN_PERF_EN
  logic [31:0] sc_a, wc_a, sc_b, wc_b;
`endif

  conv_window_gen #(.N_p(NA), .K_p(KA), .R_p(RA), .C_p(CA), .DATA_W(DW)) dut_a (
    .clk_i(clk), .reset_i(rst), .pix_v_i(pv_a), .pix_i(px_a), .pix_ready_o(pr_a),
    .win_v_o(wv_a), .win_o(w_a), .win_ch_o(ch_a), .win_row_o(row_a), .win_col_o(col_a),
    .win_last_o(wl_a), .win_ready_i(wr_a)
`ifdef CONV_WIN_PERF_EN
    , .stall_cnt_o(sc_a), .win_cnt_o(wc_a)
`endif
  );

  conv_window_gen #(.N_p(NB), .K_p(KB), .R_p(RB), .C_p(CB), .DATA_W(DW)) dut_b (
    .clk_i(clk), .reset_i(rst), .pix_v_i(pv_b), .pix_i(px_b), .pix_ready_o(pr_b),
    .win_v_o(wv_b), .win_o(w_b), .win_ch_o(ch_b), .win_row_o(row_b), .win_col_o(col_b),
    .win_last_o(wl_b), .win_ready_i(wr_b)
`ifdef CONV_WIN_PERF_EN
    , .stall_cnt_o(sc_b), .win_cnt_o(wc_b)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] src_a[$], src_b[$];
  win_t exp_a[$], exp_b[$];
  bit [1:0] mon_en = 2'b00;
  bit held[2];
  win_t snap[2];
  int cons[2];
  int lasts[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: every valid-convolution window of every frame in the source stream, in emit order.
  task automatic build(input bit s, input int n, input int k, input int r, input int c);
    int fsz, nf;
    win_t w;
    fsz = n * r * c;
    nf  = (s ? src_b.size() : src_a.size()) / fsz;
    for (int f = 0; f < nf; f++)
      for (int ch = 0; ch < n; ch++)
        for (int row = 0; row <= r - k; row++)
          for (int col = 0; col <= c - k; col++) begin
            w.d = '0;
            for (int kr = 0; kr < k; kr++)
              for (int kc = 0; kc < k; kc++) begin
                int i;
                i = f * fsz + ch * r * c + (row + kr) * c + col + kc;
                w.d[(kr*k+kc)*DW +: DW] = s ? src_b[i] : src_a[i];
              end
            w.ch   = 32'(ch);
            w.row  = 32'(row);
            w.col  = 32'(col);
            w.last = (ch == n - 1) && (row == r - k) && (col == c - k);
            if (s) exp_b.push_back(w); else exp_a.push_back(w);
          end
  endtask

  task automatic mon_step(input int s, input logic v, input logic r, input logic [MW-1:0] d,
                          input logic [31:0] ch, input logic [31:0] row, input logic [31:0] col,
                          input logic last, input logic pr);
    win_t e;
    check("pix_ready_rule", 32'(pr), 32'(!v || r));
    if (held[s]) begin
      check("hold_valid", 32'(v), 32'd1);
      checkw("hold_data", d, snap[s].d);
      check("hold_ch", ch, snap[s].ch);
      check("hold_row", row, snap[s].row);
      check("hold_col", col, snap[s].col);
      check("hold_last", 32'(last), 32'(snap[s].last));
    end
    if (v && r) begin
      cons[s]++;
      if (last) lasts[s]++;
      if ((s == 1 ? exp_b.size() : exp_a.size()) == 0) begin
        check("extra_window", 32'd1, 32'd0);
      end else begin
        e = (s == 1) ? exp_b.pop_front() : exp_a.pop_front();
        checkw("win_data", d, e.d);
        check("win_ch", ch, e.ch);
        check("win_row", row, e.row);
        check("win_col", col, e.col);
        check("win_last", 32'(last), 32'(e.last));
      end
    end
    held[s] = v && !r;
    snap[s].d = d; snap[s].ch = ch; snap[s].row = row; snap[s].col = col; snap[s].last = last;
  endtask

  always @(negedge clk) begin
    #2;
    if (mon_en[0]) mon_step(0, wv_a, wr_a, MW'(w_a), 32'(ch_a), 32'(row_a), 32'(col_a), wl_a, pr_a);
    if (mon_en[1]) mon_step(1, wv_b, wr_b, MW'(w_b), 32'(ch_b), 32'(row_b), 32'(col_b), wl_b, pr_b);
  end

  task automatic drive(input bit s, input int vp, input int rp, input bit bp, input bit drain);
    int idx = 0;
    int n;
    int cyc = 0;
    int stall = 0;
    bit bp_done = 0;
    logic v, r, wv, pr;
    n = s ? src_b.size() : src_a.size();
    while (idx < n && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      wv = s ? wv_b : wv_a;
      if (bp && !bp_done && wv) begin
        bp_done = 1;
        stall = 5;
      end
      r = (stall > 0) ? 1'b0 : ($urandom_range(99) < rp);
      v = ($urandom_range(99) < vp);
      if (s) begin pv_b = v; wr_b = r; px_b = src_b[idx]; end
      else   begin pv_a = v; wr_a = r; px_a = src_a[idx]; end
      #1;
      pr = s ? pr_b : pr_a;
      if (stall > 0) begin
        check("bp_pix_ready", 32'(pr), 32'd0);
        stall--;
      end
      if (v && pr) idx++;
    end
    check("drive_accepts", 32'(idx), 32'(n));
    if (drain) begin
      repeat (6) begin
        @(negedge clk);
        if (s) begin pv_b = 1'b0; wr_b = 1'b1; end
        else   begin pv_a = 1'b0; wr_a = 1'b1; end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    pv_a = 1'b0; wr_a = 1'b0; px_a = '0;
    pv_b = 1'b0; wr_b = 1'b0; px_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_a_win_v", 32'(wv_a), 32'd0);
    check("rst_a_last", 32'(wl_a), 32'd0);
    checkw("rst_a_win", MW'(w_a), '0);
    check("rst_a_tags", {ch_a, row_a, col_a}, 32'd0);
    check("rst_a_ready", 32'(pr_a), 32'd1);
    check("rst_b_win_v", 32'(wv_b), 32'd0);
    checkw("rst_b_win", MW'(w_b), '0);
    check("rst_b_tags", {ch_b, row_b, col_b}, 32'd0);

    // Two back-to-back frames; the first uses the ch*16 + row*4 + col pattern, then backpressure on first window.
    for (int f = 0; f < 2; f++)
      for (int n = 0; n < NA; n++)
        for (int r = 0; r < RA; r++)
          for (int c = 0; c < CA; c++)
            src_a.push_back(f == 0 ? DW'(n * 16 + r * 4 + c) : $urandom);
    build(0, NA, KA, RA, CA);
    held[0] = 0; cons[0] = 0; lasts[0] = 0;
    mon_en[0] = 1;
    drive(0, 100, 100, 1, 1);
    check("a_windows", 32'(cons[0]), 32'd36);
    check("a_last_pulses", 32'(lasts[0]), 32'd2);
    check("a_queue_empty", 32'(exp_a.size()), 32'd0);
`ifdef CONV_WIN_PERF_EN
    check("a_stall_cnt", sc_a, 32'd5);
    check("a_win_cnt", wc_a, 32'd36);
`endif

    // Reset after 7 accepts with a window pending, then a fresh frame.
    mon_en[0] = 0;
    src_a.delete();
    repeat (7) src_a.push_back($urandom);
    drive(0, 100, 100, 0, 0);
    @(negedge clk);
    pv_a = 1'b0; wr_a = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_win_v", 32'(wv_a), 32'd0);
    check("rst_mid_last", 32'(wl_a), 32'd0);
    check("rst_mid_tags", {ch_a, row_a, col_a}, 32'd0);
    check("rst_mid_ready", 32'(pr_a), 32'd1);

    src_a.delete();
    exp_a.delete();
    repeat (NA * RA * CA) src_a.push_back($urandom);
    build(0, NA, KA, RA, CA);
    held[0] = 0; cons[0] = 0; lasts[0] = 0;
    mon_en[0] = 1;
    drive(0, 70, 70, 0, 1);
    check("a_post_rst_windows", 32'(cons[0]), 32'd18);
    check("a_post_rst_last", 32'(lasts[0]), 32'd1);
    check("a_post_rst_empty", 32'(exp_a.size()), 32'd0);

    // Random valid/ready, K=3 on 6x6 with 4 channels.
    repeat (NB * RB * CB) src_b.push_back($urandom);
    build(1, NB, KB, RB, CB);
    held[1] = 0; cons[1] = 0; lasts[1] = 0;
    mon_en[1] = 1;
    drive(1, 50, 50, 0, 1);
    check("b_windows", 32'(cons[1]), 32'd64);
    check("b_last_pulses", 32'(lasts[1]), 32'd1);
    check("b_queue_empty", 32'(exp_b.size()), 32'd0);

    mon_en = 2'b00;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
